// File: rtl/demux1_8_seq_if.sv
// Bus bundle for demux1_8_seq: serial input side (d/valid/s/auto) and the
// registered demux outputs.
interface demux1_8_seq_if;
  // valid-only handshake: d (and s when auto=0) is taken on every rising clk
  // edge where valid=1; there is no ready, so the sink always accepts.
  logic       d;
  logic       valid;
  logic [2:0] s;
  logic       auto;
  logic [7:0] y;
  logic       done;
  logic       busy;
  logic [2:0] idx;
  logic       par;
  logic       dbg_state;

  modport master (
    output d, valid, s, auto,
    input  y, done, busy, idx, par, dbg_state
  );

  modport slave (
    input  d, valid, s, auto,
    output y, done, busy, idx, par, dbg_state
  );
endinterface

// File: rtl/demux1_8_seq.sv
// Sequential 1-to-8 demux: addressed bit writes or auto-mode 8-bit frames.
// Optional even parity of y is built when DEMUX1_8_PARITY_EN is defined.
module demux1_8_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  demux1_8_seq_if.slave bus
);
  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_IDX  = MSB_FIRST ? 3'd0 : 3'd7;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [7:0] r_shadow;
  logic [7:0] r_y;
  logic       r_done;

  logic [7:0] w_frame;
  logic [7:0] w_y_next;
  logic [2:0] w_idx_step;
  logic       w_final;

  assign w_idx_step = MSB_FIRST ? (r_idx - 3'd1) : (r_idx + 3'd1);
  assign w_final    = (r_idx == LAST_IDX);

  // The final bit bypasses the shadow so the whole byte lands in y on one edge.
  always_comb begin
    w_frame        = r_shadow;
    w_frame[r_idx] = bus.d;
    w_y_next       = r_y;
    if (!bus.auto) begin
      if (bus.valid) w_y_next[bus.s] = bus.d;
    end else if (bus.valid && w_final) begin
      w_y_next = w_frame;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= START_IDX;
      r_shadow <= 8'h00;
      r_y      <= 8'h00;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_y    <= w_y_next;
      if (!bus.auto) begin
        // Leaving auto mode mid-frame drops the partial frame.
        if (r_state == S_COLLECT) begin
          r_state <= S_IDLE;
          r_idx   <= START_IDX;
        end
      end else if (bus.valid) begin
        if (w_final) begin
          r_done  <= 1'b1;
          r_idx   <= START_IDX;
          r_state <= S_IDLE;
        end else begin
          r_shadow[r_idx] <= bus.d;
          r_idx           <= w_idx_step;
          r_state         <= S_COLLECT;
        end
      end
    end
  end

`ifdef DEMUX1_8_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_par <= 1'b0;
    else     r_par <= ^w_y_next;
  end

  assign bus.par = r_par;
`else
  assign bus.par = 1'b0;
`endif

  assign bus.y         = r_y;
  assign bus.done      = r_done;
  assign bus.busy      = (r_state == S_COLLECT);
  assign bus.idx       = r_idx;
  assign bus.dbg_state = (r_state == S_COLLECT);
endmodule

// File: tb/tb_demux1_8_seq.sv
// Bench for demux1_8_seq: LSB-first and MSB-first instances share stimulus and
// are compared each cycle against a frame-level reference model.
module tb_demux1_8_seq;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  demux1_8_seq_if bus0 ();
  demux1_8_seq_if bus1 ();

  demux1_8_seq #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  demux1_8_seq #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bits in arrival order, mapped to positions on completion.
  logic [7:0] m_y    [2];
  logic       m_seq  [2][8];
  int         m_cnt  [2];
  logic       m_done [2];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_y[k]    = 8'h00;
      m_cnt[k]  = 0;
      m_done[k] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_edge(input logic din, input logic vin, input logic [2:0] sin, input logic ain);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (!ain) begin
        m_cnt[k] = 0;
        if (vin) m_y[k][sin] = din;
      end else if (vin) begin
        m_seq[k][m_cnt[k]] = din;
        m_cnt[k]++;
        if (m_cnt[k] == 8) begin
          for (int i = 0; i < 8; i++) m_y[k][(k == 1) ? 7 - i : i] = m_seq[k][i];
          m_done[k] = 1'b1;
          m_cnt[k]  = 0;
          if (k == 0) exp_q.push_back(m_y[0]);
        end
      end
    end
  endtask

  function automatic logic exp_par(input logic [7:0] v);
`ifdef DEMUX1_8_PARITY_EN
    return ^v;
`else
    return 1'b0 & v[0];
`endif
  endfunction

  task automatic check_dut(input int k, input logic [7:0] y, input logic done,
                           input logic busy, input logic [2:0] idx, input logic par);
    logic [2:0] e_idx;
    e_idx = (k == 1) ? 3'(7 - m_cnt[k]) : 3'(m_cnt[k]);
    check($sformatf("y%0d", k), y, m_y[k]);
    check($sformatf("done%0d", k), {7'd0, done}, {7'd0, m_done[k]});
    check($sformatf("busy%0d", k), {7'd0, busy}, {7'd0, m_cnt[k] > 0});
    check($sformatf("idx%0d", k), {5'd0, idx}, {5'd0, e_idx});
    check($sformatf("par%0d", k), {7'd0, par}, {7'd0, exp_par(m_y[k])});
  endtask

  task automatic check_all();
    logic [7:0] fr;
    check_dut(0, bus0.y, bus0.done, bus0.busy, bus0.idx, bus0.par);
    check_dut(1, bus1.y, bus1.done, bus1.busy, bus1.idx, bus1.par);
    if (bus0.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("frame_unexpected", bus0.y, ~bus0.y);
      end else begin
        fr = exp_q.pop_front();
        check("frame", bus0.y, fr);
      end
    end
  endtask

  task automatic drive(input logic din, input logic vin, input logic [2:0] sin, input logic ain);
    bus0.d = din; bus0.valid = vin; bus0.s = sin; bus0.auto = ain;
    bus1.d = din; bus1.valid = vin; bus1.s = sin; bus1.auto = ain;
    @(posedge clk);
    model_edge(din, vin, sin, ain);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset raised between edges and checked before any clock edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  task automatic send_byte_auto(input logic [7:0] bits_in_order);
    logic [7:0] b;
    b = bits_in_order;
    for (int i = 0; i < 8; i++) drive(b[i], 1'b1, 3'd0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Addressed: y[s] <= s[0]
    for (int i = 0; i < 8; i++) drive(i[0], 1'b1, 3'(i), 1'b0);
    check("addr_y0", bus0.y, 8'hAA);
    check("addr_y1", bus1.y, 8'hAA);

    // Mid-frame async reset: no done for the aborted frame
    drive(1'b1, 1'b1, 3'd0, 1'b1);
    drive(1'b1, 1'b1, 3'd0, 1'b1);
    drive(1'b1, 1'b1, 3'd0, 1'b1);
    async_reset();
    check("rst_y0", bus0.y, 8'h00);

    // Auto frames back to back: 0,1,0,1,... then eight 1s
    send_byte_auto(8'hAA);
    check("auto_aa_y0", bus0.y, 8'hAA);
    check("auto_aa_y1", bus1.y, 8'h55);
    check("auto_aa_done0", {7'd0, bus0.done}, 8'h01);
    send_byte_auto(8'hFF);
    check("auto_ff_y0", bus0.y, 8'hFF);
    drive(1'b0, 1'b0, 3'd0, 1'b1);
    check("done_one_cycle", {7'd0, bus0.done}, 8'h00);

    // Auto with a 3-cycle gap between bits 3 and 4
    async_reset();
    for (int i = 0; i < 4; i++) drive(i[0], 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd0, 1'b1);
      check("gap_busy", {7'd0, bus0.busy}, 8'h01);
      check("gap_hold", bus0.y, 8'h00);
    end
    for (int i = 4; i < 8; i++) drive(i[0], 1'b1, 3'd0, 1'b1);
    check("gap_y0", bus0.y, 8'hAA);

    // Abort: 5 bits then auto falls with an addressed write on the same edge
    async_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 3'd0, 1'b1);
    drive(1'b1, 1'b1, 3'd2, 1'b0);
    check("abort_y0", bus0.y, 8'h04);
    check("abort_y1", bus1.y, 8'h04);
    check("abort_idx1", {5'd0, bus1.idx}, 8'h07);

    // MSB-first frames with parity
    async_reset();
    send_byte_auto(8'b1000_0001);
    check("msb_81", bus1.y, 8'h81);
    send_byte_auto(8'b0000_0001);
    check("msb_80", bus1.y, 8'h80);
    check("lsb_01", bus0.y, 8'h01);

    // Randomized traffic with occasional mode flips and one async reset
    begin
      logic a;
      a = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) a = ~a;
        if (i == 1500) async_reset();
        drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
              3'($urandom_range(0, 7)), a);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
